// File: rtl/u21_ref.sv
// u21_ref: configuration lookup for the u21 universal two-input gate cell.
//
// Given a 2-input Boolean function (4-bit truth table, func[k] = f(a,b) for
// minterm k) and a configuration pin index, return the source tied to that
// pin. The possible sources are const 0, const 1, input a and input b. The
// result is registered, so it appears one clock after the inputs are sampled.
//
// Optional build macro: U21_REF_ALLPINS_EN
//   When it is defined, the block also has a registered output wiring_all[11:0].
//   This output holds the complete pin map for func, with pin p in bits [3*p+:3].
//   It does not depend on pin.
//
// Reset is synchronous and active-low. It clears every output register to 0.
module u21_ref (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  func,
    input  logic [1:0]  pin,
    output logic [2:0]  wiring
`ifdef U21_REF_ALLPINS_EN
    ,
    output logic [11:0] wiring_all
`endif
);

    // Source codes driven onto the 3-bit wiring field. Bit 2 is always zero.
    localparam logic [2:0] SRC_O = 3'd0;  // constant 0
    localparam logic [2:0] SRC_I = 3'd1;  // constant 1
    localparam logic [2:0] SRC_A = 3'd2;  // input a
    localparam logic [2:0] SRC_B = 3'd3;  // input b

    // Full pin map for one function. Element [p] is the source for pin p.
    typedef logic [3:0][2:0] pin_map_t;

    // Pin ties for each of the 16 two-input functions.
    // In each concatenation, pin 3 comes first and pin 0 comes last.
    function automatic pin_map_t lookup_map(input logic [3:0] f);
        pin_map_t m;
        m = {SRC_O, SRC_O, SRC_O, SRC_O};
        case (f)
            4'h0: m = {SRC_O, SRC_O, SRC_O, SRC_O};
            4'h1: m = {SRC_A, SRC_B, SRC_A, SRC_O};
            4'h2: m = {SRC_B, SRC_A, SRC_O, SRC_O};
            4'h3: m = {SRC_B, SRC_O, SRC_O, SRC_O};
            4'h4: m = {SRC_A, SRC_B, SRC_O, SRC_O};
            4'h5: m = {SRC_A, SRC_O, SRC_O, SRC_O};
            4'h6: m = {SRC_B, SRC_O, SRC_A, SRC_O};
            4'h7: m = {SRC_B, SRC_A, SRC_A, SRC_O};
            4'h8: m = {SRC_B, SRC_A, SRC_A, SRC_I};
            4'h9: m = {SRC_I, SRC_B, SRC_A, SRC_O};
            4'hA: m = {SRC_I, SRC_A, SRC_O, SRC_O};
            4'hB: m = {SRC_A, SRC_B, SRC_I, SRC_O};
            4'hC: m = {SRC_I, SRC_B, SRC_O, SRC_O};
            4'hD: m = {SRC_B, SRC_A, SRC_I, SRC_O};
            4'hE: m = {SRC_A, SRC_B, SRC_A, SRC_I};
            4'hF: m = {SRC_I, SRC_O, SRC_O, SRC_O};
            default: m = {SRC_O, SRC_O, SRC_O, SRC_O};
        endcase
        return m;
    endfunction

    pin_map_t   map_now;
    logic [2:0] code;

    // Combinational lookup of the full map and of the queried pin's source.
    always_comb begin
        // NOTE: give every always_comb output a default first. Then no path leaves it unassigned, and no latch is inferred.
        map_now = '0;
        code    = SRC_O;
        map_now = lookup_map(func);
        code    = map_now[pin];
    end

    // Register the selected source. Reset has priority over the lookup.
    always_ff @(posedge clk) begin
        // NOTE: use non-blocking assignments for state, so every flop samples its pre-edge inputs.
        if (!rst_n) begin
            wiring <= 3'd0;
        end else begin
            wiring <= code;
        end
    end

`ifdef U21_REF_ALLPINS_EN
    // Register the full pin map on the same edge as wiring.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wiring_all <= 12'd0;
        end else begin
            wiring_all <= map_now;
        end
    end
`endif

endmodule

// File: tb/tb_u21_ref.sv
// tb_u21_ref: directed, table-driven check of u21_ref.
// Inputs change on the falling edge. Outputs are sampled 1 time unit after the rising edge.
module tb_u21_ref;

    logic        clk;
    logic        rst_n;
    logic [3:0]  func;
    logic [1:0]  pin;
    logic [2:0]  wiring;
`ifdef U21_REF_ALLPINS_EN
    logic [11:0] wiring_all;
`endif

    int errors = 0;
    int checks = 0;

    u21_ref dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .func       (func),
        .pin        (pin),
        .wiring     (wiring)
`ifdef U21_REF_ALLPINS_EN
        ,
        .wiring_all (wiring_all)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference table transcribed by hand: exp_tbl[func][pin]. O=0, I=1, a=2, b=3.
    int unsigned exp_tbl [16][4] = '{
        '{0,0,0,0}, '{0,2,3,2}, '{0,0,2,3}, '{0,0,0,3},
        '{0,0,3,2}, '{0,0,0,2}, '{0,2,0,3}, '{0,2,2,3},
        '{1,2,2,3}, '{0,2,3,1}, '{0,0,2,1}, '{0,1,3,2},
        '{0,0,3,1}, '{0,1,2,3}, '{1,2,3,2}, '{0,0,0,1}
    };

    typedef struct {
        logic [3:0] f;
        logic [1:0] p;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and sample after the edge.
    task automatic step(input logic [3:0] f, input logic [1:0] p, input logic r);
        @(negedge clk);
        func  = f;
        pin   = p;
        rst_n = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        func  = 4'h0;
        pin   = 2'd0;

        // Directed spot vectors and constant cases, with hand-computed expected values.
        vecs[0]  = '{4'h1, 2'd3, 3'd2};
        vecs[1]  = '{4'h1, 2'd2, 3'd3};
        vecs[2]  = '{4'h1, 2'd1, 3'd2};
        vecs[3]  = '{4'h1, 2'd0, 3'd0};
        vecs[4]  = '{4'h9, 2'd3, 3'd1};
        vecs[5]  = '{4'h9, 2'd2, 3'd3};
        vecs[6]  = '{4'h9, 2'd1, 3'd2};
        vecs[7]  = '{4'h9, 2'd0, 3'd0};
        vecs[8]  = '{4'h0, 2'd3, 3'd0};
        vecs[9]  = '{4'hF, 2'd3, 3'd1};
        vecs[10] = '{4'hF, 2'd2, 3'd0};
        vecs[11] = '{4'hF, 2'd0, 3'd0};
        vecs[12] = '{4'h8, 2'd0, 3'd1};
        vecs[13] = '{4'hE, 2'd0, 3'd1};

        // Hold reset for two edges with func=E and pin=3.
        step(4'hE, 2'd3, 1'b0);
        check("reset_edge1", {9'd0, wiring}, 12'd0);
        step(4'hE, 2'd3, 1'b0);
        check("reset_edge2", {9'd0, wiring}, 12'd0);
`ifdef U21_REF_ALLPINS_EN
        check("reset_all", wiring_all, 12'd0);
`endif
        // First edge after release gives the looked-up value (a).
        step(4'hE, 2'd3, 1'b1);
        check("post_reset", {9'd0, wiring}, 12'd2);

        // Apply the directed vectors.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].f, vecs[i].p, 1'b1);
            check($sformatf("vec%0d_f%0h_p%0d", i, vecs[i].f, vecs[i].p),
                  {9'd0, wiring}, {9'd0, vecs[i].exp});
        end

        // Exhaustive sweep, one combination per cycle. Reset is pulsed once mid-stream.
        for (int i = 0; i < 64; i++) begin
            logic [3:0] f;
            logic [1:0] p;
            f = 4'(i / 4);
            p = 2'(i % 4);
            if (i == 37) begin
                step(f, p, 1'b0);
                check("midstream_reset", {9'd0, wiring}, 12'd0);
            end
            step(f, p, 1'b1);
            check($sformatf("sweep_f%0h_p%0d", f, p), {9'd0, wiring}, 12'(exp_tbl[f][p]));
        end

        // Back-to-back alternation between func=3/pin=3 and func=A/pin=2.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                step(4'h3, 2'd3, 1'b1);
                check($sformatf("alt%0d_f3p3", i), {9'd0, wiring}, 12'd3);
            end else begin
                step(4'hA, 2'd2, 1'b1);
                check($sformatf("alt%0d_fAp2", i), {9'd0, wiring}, 12'd2);
            end
        end

        // Confirm the one-cycle lag: the output still holds the old value just before the edge.
        @(negedge clk);
        func = 4'hF;
        pin  = 2'd3;
        #1;
        check("lag_hold", {9'd0, wiring}, 12'd2);
        @(posedge clk);
        #1;
        check("lag_update", {9'd0, wiring}, 12'd1);

`ifdef U21_REF_ALLPINS_EN
        step(4'hB, 2'd0, 1'b1);
        check("all_fB", wiring_all, {3'd2, 3'd3, 3'd1, 3'd0});
        step(4'h8, 2'd3, 1'b1);
        check("all_f8", wiring_all, {3'd3, 3'd2, 3'd2, 3'd1});
        step(4'hB, 2'd1, 1'b0);
        check("all_reset", wiring_all, 12'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
